// File: rtl/fb_rect_filler.sv
// Rectangle-fill write engine for the 256x256 framebuffer: walks a clipped
// rectangle row-major and issues one granted write per cycle at {y, x}.
module fb_rect_filler #(
    parameter int H_BITS  = 8,
    parameter int V_BITS  = 8,
    parameter int PIXEL_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [H_BITS-1:0]          cmd_x,
    input  logic [V_BITS-1:0]          cmd_y,
    input  logic [H_BITS-1:0]          cmd_w,
    input  logic [V_BITS-1:0]          cmd_h,
    input  logic [PIXEL_W-1:0]         cmd_color,
    output logic [H_BITS+V_BITS-1:0]   fb_addr,
    output logic [PIXEL_W-1:0]         fb_wdata,
    output logic                       fb_we,
    input  logic                       fb_gnt,
    output logic                       busy,
    output logic                       done
);

    // state  | meaning
    // S_IDLE | ready for a command
    // S_FILL | issuing writes, advancing only on grant
    // S_DONE | one-cycle done pulse before returning to idle
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t               state_q;
    logic [H_BITS-1:0]    x_q, x0_q, x_end_q;
    logic [V_BITS-1:0]    y_q, y_end_q;
    logic [PIXEL_W-1:0]   color_q;
    logic                 ready_q, we_q, busy_q, done_q;

    // One extra bit on the sums so a rectangle running off the edge clips
    // to the last column/row instead of wrapping to the opposite side.
    logic [H_BITS:0]      x_sum;
    logic [V_BITS:0]      y_sum;
    logic [H_BITS-1:0]    x_end_d;
    logic [V_BITS-1:0]    y_end_d;

    assign x_sum   = {1'b0, cmd_x} + {1'b0, cmd_w};
    assign y_sum   = {1'b0, cmd_y} + {1'b0, cmd_h};
    assign x_end_d = x_sum[H_BITS] ? {H_BITS{1'b1}} : x_sum[H_BITS-1:0];
    assign y_end_d = y_sum[V_BITS] ? {V_BITS{1'b1}} : y_sum[V_BITS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            x0_q    <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            color_q <= '0;
            ready_q <= 1'b1;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (cmd_valid) begin
                        x_q     <= cmd_x;
                        y_q     <= cmd_y;
                        x0_q    <= cmd_x;
                        x_end_q <= x_end_d;
                        y_end_q <= y_end_d;
                        color_q <= cmd_color;
                        ready_q <= 1'b0;
                        we_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (fb_gnt) begin
                        if (x_q == x_end_q && y_q == y_end_q) begin
                            we_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (x_q < x_end_q) begin
                            x_q <= x_q + 1'b1;
                        end else begin
                            x_q <= x0_q;
                            y_q <= y_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign fb_we     = we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fb_addr   = {y_q, x_q};
    assign fb_wdata  = color_q;

endmodule

// File: tb/tb_fb_rect_filler.sv
// Directed bench for fb_rect_filler: hand-computed addresses, timing and
// handshake expectations, plus a row-major reference walk of each rectangle.
module tb_fb_rect_filler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0, cmd_color = '0;
    logic [15:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        fb_we;
    logic        fb_gnt = 1'b1;
    logic        busy, done;

    int errors = 0;
    int checks = 0;

    logic [15:0] wr[$];
    logic [15:0] seen[$];
    int          done_k;
    int          busy_cnt;
    int          done_k_ref;

    localparam logic        B2B_WE   [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam logic [15:0] B2B_ADDR [8] = '{16'h0201, 16'h0202, 16'h0301, 16'h0302,
                                            16'h0000, 16'h0000, 16'h9080, 16'h0000};
    localparam logic [7:0]  B2B_DATA [8] = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h00, 8'h00, 8'h22, 8'h00};
    localparam logic        B2B_DONE [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic        B2B_RDY  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    fb_rect_filler #(.H_BITS(8), .V_BITS(8), .PIXEL_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .fb_we     (fb_we),
        .fb_gnt    (fb_gnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command, runs it to done, and compares granted writes
    // against a row-major walk of the clipped rectangle.
    task automatic run_fill(input string tag, input int x, input int y, input int w,
                            input int h, input logic [7:0] color, input int stall);
        logic [15:0] ref_q[$];
        int xe, ye, k;
        bit got_done;
        wr.delete();
        seen.delete();
        busy_cnt = 0;
        done_k   = -1;
        got_done = 0;
        cmd_x = x[7:0]; cmd_y = y[7:0]; cmd_w = w[7:0]; cmd_h = h[7:0];
        cmd_color = color;
        cmd_valid = 1'b1;
        fb_gnt = 1'b1;
        chk({tag, "_ready_pre"}, cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        for (k = 1; k <= 600 && !got_done; k++) begin
            fb_gnt = (k > stall);
            if (fb_we) seen.push_back(fb_addr);
            if (fb_we && fb_gnt) begin
                wr.push_back(fb_addr);
                if (fb_wdata !== color) chk({tag, "_wdata"}, fb_wdata, color);
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_k = k;
                got_done = 1;
            end else begin
                tick();
            end
        end
        if (!got_done) chk({tag, "_timeout"}, 32'd0, 32'd1);
        fb_gnt = 1'b1;
        tick();
        chk({tag, "_done_single"}, done, 1'b0);
        chk({tag, "_ready_post"}, cmd_ready, 1'b1);

        xe = (x + w > 255) ? 255 : x + w;
        ye = (y + h > 255) ? 255 : y + h;
        for (int yy = y; yy <= ye; yy++)
            for (int xx = x; xx <= xe; xx++)
                ref_q.push_back({yy[7:0], xx[7:0]});
        chk({tag, "_nwrites"}, wr.size(), ref_q.size());
        for (int i = 0; i < ref_q.size() && i < wr.size(); i++)
            if (wr[i] !== ref_q[i]) chk({tag, "_addr"}, wr[i], ref_q[i]);
    endtask

    initial begin
        // reset values
        #12;
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_we", fb_we, 1'b0);
        chk("rst_addr", fb_addr, 16'h0000);
        chk("rst_wdata", fb_wdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // single pixel, exact cycle timing
        cmd_x = 8'd5; cmd_y = 8'd7; cmd_w = 8'd0; cmd_h = 8'd0; cmd_color = 8'hA3;
        cmd_valid = 1'b1; fb_gnt = 1'b1;
        chk("px_ready0", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chk("px_we1", fb_we, 1'b1);
        chk("px_addr1", fb_addr, 16'h0705);
        chk("px_data1", fb_wdata, 8'hA3);
        chk("px_busy1", busy, 1'b1);
        chk("px_ready1", cmd_ready, 1'b0);
        chk("px_done1", done, 1'b0);
        tick();
        chk("px_we2", fb_we, 1'b0);
        chk("px_done2", done, 1'b1);
        chk("px_busy2", busy, 1'b0);
        chk("px_ready2", cmd_ready, 1'b0);
        tick();
        chk("px_done3", done, 1'b0);
        chk("px_ready3", cmd_ready, 1'b1);
        tick();

        // 3x2 rectangle
        run_fill("r3x2", 10, 20, 2, 1, 8'h5C, 0);
        chk("r3x2_first", wr.size() > 0 ? wr[0] : 16'hxxxx, 16'h140A);
        chk("r3x2_third", wr.size() > 2 ? wr[2] : 16'hxxxx, 16'h140C);
        chk("r3x2_fourth", wr.size() > 3 ? wr[3] : 16'hxxxx, 16'h150A);
        chk("r3x2_last", wr.size() > 5 ? wr[5] : 16'hxxxx, 16'h150C);
        chk("r3x2_busy", busy_cnt, 6);
        chk("r3x2_done_k", done_k, 7);

        // clip at the bottom-right corner
        run_fill("clip", 254, 255, 3, 3, 8'h7E, 0);
        chk("clip_n", wr.size(), 2);
        chk("clip_a0", wr.size() > 0 ? wr[0] : 16'hxxxx, 16'hFFFE);
        chk("clip_a1", wr.size() > 1 ? wr[1] : 16'hxxxx, 16'hFFFF);

        // clip on the right edge only
        run_fill("clipx", 250, 10, 10, 0, 8'h01, 0);
        chk("clipx_n", wr.size(), 6);
        chk("clipx_last", wr.size() > 5 ? wr[5] : 16'hxxxx, 16'h0AFF);

        // grant stalls: unstalled reference, then 3 stall cycles on the first pixel
        run_fill("nostall", 48, 64, 1, 0, 8'h9D, 0);
        chk("nostall_done_k", done_k, 3);
        done_k_ref = done_k;
        run_fill("stall", 48, 64, 1, 0, 8'h9D, 3);
        chk("stall_seen_n", seen.size(), 5);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk("stall_hold", seen[i], 16'h4030);
        chk("stall_second", wr.size() > 1 ? wr[1] : 16'hxxxx, 16'h4031);
        chk("stall_done_k", done_k, 6);
        chk("stall_delta", done_k - done_k_ref, 3);

        // back-to-back with cmd_color churn during the first fill
        cmd_x = 8'd1; cmd_y = 8'd2; cmd_w = 8'd1; cmd_h = 8'd1; cmd_color = 8'h11;
        cmd_valid = 1'b1; fb_gnt = 1'b1;
        tick();
        cmd_x = 8'h80; cmd_y = 8'h90; cmd_w = 8'd0; cmd_h = 8'd0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 4) cmd_color = k[0] ? 8'h33 : 8'h44;
            else cmd_color = 8'h22;
            if (k == 7) cmd_valid = 1'b0;
            chk($sformatf("b2b_we%0d", k), fb_we, B2B_WE[k-1]);
            if (B2B_WE[k-1]) begin
                chk($sformatf("b2b_addr%0d", k), fb_addr, B2B_ADDR[k-1]);
                chk($sformatf("b2b_data%0d", k), fb_wdata, B2B_DATA[k-1]);
            end
            chk($sformatf("b2b_done%0d", k), done, B2B_DONE[k-1]);
            chk($sformatf("b2b_ready%0d", k), cmd_ready, B2B_RDY[k-1]);
            tick();
        end
        cmd_valid = 1'b0;
        tick();

        // async reset in the middle of a 16x16 fill
        cmd_x = 8'h10; cmd_y = 8'h20; cmd_w = 8'd15; cmd_h = 8'd15; cmd_color = 8'hC4;
        cmd_valid = 1'b1; fb_gnt = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("mid_we_before", fb_we, 1'b1);
        chk("mid_addr_before", fb_addr, 16'h2114);
        rst_n = 1'b0;
        #1;
        chk("arst_we", fb_we, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_ready", cmd_ready, 1'b1);
        tick();
        chk("arst_we_hold", fb_we, 1'b0);
        chk("arst_done_hold", done, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_we", fb_we, 1'b0);
        chk("post_rst_done", done, 1'b0);
        run_fill("post_rst", 3, 4, 1, 1, 8'h66, 0);
        chk("post_rst_first", wr.size() > 0 ? wr[0] : 16'hxxxx, 16'h0403);
        chk("post_rst_last", wr.size() > 3 ? wr[3] : 16'hxxxx, 16'h0504);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
